// File: rtl/mux8_share_arbiter_pkg.sv
// Shared encodings for the two-port byte arbiter: FSM states and datapath width.
package arb_pkg;

  localparam int ARB_W = 8;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'b00,
    ARB_OWN0 = 2'b01,
    ARB_OWN1 = 2'b10
  } arb_state_e;

endpackage

// File: rtl/mux8_share_arbiter_mux.sv
// Shared 8-bit 2:1 datapath mux; purely combinational, s=1 selects i1.
module MUX_2to1_8Bit
  import arb_pkg::*;
(
  input  logic [ARB_W-1:0] i0,
  input  logic [ARB_W-1:0] i1,
  input  logic             s,
  output logic [ARB_W-1:0] y
);

  assign y = s ? i1 : i0;

endmodule

// File: rtl/mux8_share_arbiter.sv
// Two-port byte arbiter into a 1-entry output register: accept->out_valid 1 cycle, grants stall while the register is full and out_ready=0.
// ARB_RR_EN selects round-robin with MAX_BEATS burst limit; default build is fixed priority (port 0 first).
module mux8_share_arbiter
  import arb_pkg::*;
#(
  parameter int MAX_BEATS = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic [ARB_W-1:0] data0,
  output logic             gnt0,
  input  logic             req1,
  input  logic [ARB_W-1:0] data1,
  output logic             gnt1,
  output logic             sel,
  output logic             out_valid,
  output logic [ARB_W-1:0] out_data,
  input  logic             out_ready
);

  arb_state_e       state_q, state_d;
  logic             out_valid_q, out_valid_d;
  logic [ARB_W-1:0] out_data_q, out_data_d;
  logic [ARB_W-1:0] mux_y;
  logic             can_take;
  logic             win0, win1;

`ifdef ARB_RR_EN
  logic [3:0] cnt_q, cnt_d;
  logic       last_q, last_d;
  logic       under_limit;

  assign under_limit = cnt_q < 4'(MAX_BEATS - 1);
`endif

  MUX_2to1_8Bit u_mux (
    .i0 (data0),
    .i1 (data1),
    .s  (sel),
    .y  (mux_y)
  );

  // Winner selection: who would be granted if the output register can take a byte.
  always_comb begin
    win0 = 1'b0;
    win1 = 1'b0;
`ifdef ARB_RR_EN
    case (state_q)
      ARB_OWN0: begin
        if (req0 && (!req1 || under_limit)) win0 = 1'b1;
        else if (req1)                      win1 = 1'b1;
      end
      ARB_OWN1: begin
        if (req1 && (!req0 || under_limit)) win1 = 1'b1;
        else if (req0)                      win0 = 1'b1;
      end
      default: begin
        if (req0 && req1) begin
          win0 = last_q;
          win1 = !last_q;
        end else begin
          win0 = req0;
          win1 = req1;
        end
      end
    endcase
`else
    win0 = req0;
    win1 = !req0 && req1;
`endif
  end

  // Outputs: grants are masked during reset so gnt/sel read 0 without a clock.
  always_comb begin
    can_take = !out_valid_q || out_ready;
    gnt0     = rst_n && can_take && win0;
    gnt1     = rst_n && can_take && win1;
    sel      = gnt1;
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
`ifdef ARB_RR_EN
    cnt_d       = cnt_q;
    last_d      = last_q;
`endif
    if (gnt0 || gnt1) begin
      out_data_d  = mux_y;
      out_valid_d = 1'b1;
      state_d     = gnt1 ? ARB_OWN1 : ARB_OWN0;
`ifdef ARB_RR_EN
      last_d      = gnt1;
      if (state_d == state_q) cnt_d = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;
      else                    cnt_d = 4'd0;
`endif
    end else if (can_take) begin
      state_d = ARB_IDLE;
`ifdef ARB_RR_EN
      cnt_d   = 4'd0;
`endif
      if (out_ready) out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ARB_IDLE;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
`ifdef ARB_RR_EN
      cnt_q       <= 4'd0;
      last_q      <= 1'b1;
`endif
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
`ifdef ARB_RR_EN
      cnt_q       <= cnt_d;
      last_q      <= last_d;
`endif
    end
  end

endmodule

// File: tb/tb_mux8_share_arbiter.sv
// Directed bench for mux8_share_arbiter; expectations follow ARB_RR_EN when the bench is built with it.
module tb_mux8_share_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0, req1, out_ready;
  logic [7:0] data0, data1;
  logic       gnt0, gnt1, sel, out_valid;
  logic [7:0] out_data;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mux8_share_arbiter #(.MAX_BEATS(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req0      (req0),
    .data0     (data0),
    .gnt0      (gnt0),
    .req1      (req1),
    .data1     (data1),
    .gnt1      (gnt1),
    .sel       (sel),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Called just after a rising edge with inputs already driven: checks the
  // combinational grant before the next edge, then the registered output after it.
  task automatic cyc(input string tag, input logic eg0, input logic eg1,
                     input logic ev, input logic [7:0] ed);
    @(negedge clk);
    chk({tag, ".gnt0"}, 32'(gnt0), 32'(eg0));
    chk({tag, ".gnt1"}, 32'(gnt1), 32'(eg1));
    chk({tag, ".sel"},  32'(sel),  32'(eg1));
    @(posedge clk);
    #1;
    chk({tag, ".vld"},  32'(out_valid), 32'(ev));
    chk({tag, ".dat"},  32'(out_data),  32'(ed));
  endtask

  initial begin
    rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0; out_ready = 1'b0;
    data0 = 8'h00; data1 = 8'h00;

    #2;
    chk("rst.vld",  32'(out_valid), 32'd0);
    chk("rst.dat",  32'(out_data),  32'h00);
    chk("rst.gnt0", 32'(gnt0), 32'd0);
    chk("rst.gnt1", 32'(gnt1), 32'd0);
    chk("rst.sel",  32'(sel),  32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Contention: both ports held, burst limit 4.
    req0 = 1'b1; req1 = 1'b1; data0 = 8'h11; data1 = 8'h22; out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      logic p1;
`ifdef ARB_RR_EN
      p1 = ((i / 4) % 2) == 1;
`else
      p1 = 1'b0;
`endif
      cyc($sformatf("cont%0d", i), !p1, p1, 1'b1, p1 ? 8'h22 : 8'h11);
    end
    req0 = 1'b0; req1 = 1'b0;
    cyc("idle0", 1'b0, 1'b0, 1'b0, 8'h11);

    // Single beat.
    req0 = 1'b1; data0 = 8'hA5;
    cyc("single", 1'b1, 1'b0, 1'b1, 8'hA5);

    // Backpressure: full register, downstream not ready.
    req0 = 1'b0; req1 = 1'b1; data1 = 8'h3C; out_ready = 1'b0;
    cyc("stall0", 1'b0, 1'b0, 1'b1, 8'hA5);
    cyc("stall1", 1'b0, 1'b0, 1'b1, 8'hA5);
    out_ready = 1'b1;
    cyc("unstall", 1'b0, 1'b1, 1'b1, 8'h3C);
    req1 = 1'b0;
    cyc("idle1", 1'b0, 1'b0, 1'b0, 8'h3C);

    // Tie-break after a port 1 burst, then after a port 0 burst.
    req0 = 1'b1; req1 = 1'b1; data0 = 8'h11; data1 = 8'h22;
    cyc("tie0", 1'b1, 1'b0, 1'b1, 8'h11);
    req1 = 1'b0; data0 = 8'h12;
    cyc("p0b1", 1'b1, 1'b0, 1'b1, 8'h12);
    data0 = 8'h13;
    cyc("p0b2", 1'b1, 1'b0, 1'b1, 8'h13);
    req0 = 1'b0;
    cyc("idle2", 1'b0, 1'b0, 1'b0, 8'h13);
    req0 = 1'b1; req1 = 1'b1; data0 = 8'h44; data1 = 8'h55;
`ifdef ARB_RR_EN
    cyc("tie1", 1'b0, 1'b1, 1'b1, 8'h55);
`else
    cyc("tie1", 1'b1, 1'b0, 1'b1, 8'h44);
`endif

    // Reset mid-burst with a byte waiting in the output register.
    #2;
    rst_n = 1'b0;
    #1;
    chk("mrst.vld",  32'(out_valid), 32'd0);
    chk("mrst.dat",  32'(out_data),  32'h00);
    chk("mrst.gnt0", 32'(gnt0), 32'd0);
    chk("mrst.gnt1", 32'(gnt1), 32'd0);
    chk("mrst.sel",  32'(sel),  32'd0);
    req1 = 1'b0; data0 = 8'h5A;
    @(posedge clk);
    #1;
    chk("mrst.hold", 32'(out_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post.gnt0", 32'(gnt0), 32'd1);
    @(posedge clk);
    #1;
    chk("post.vld", 32'(out_valid), 32'd1);
    chk("post.dat", 32'(out_data),  32'h5A);
    req0 = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
